// File: rtl/inst_prefetch_pkg.sv
// Shared fetch-path types and constants for the instruction prefetch unit.
package inst_prefetch_pkg;

    typedef logic [31:0] InstAddr_t;
    typedef logic [31:0] Inst_t;

    localparam Inst_t ZeroWord      = 32'h0000_0000;
    localparam logic  RstEnable     = 1'b1;
    localparam logic  ChipEnable    = 1'b1;
    localparam logic  ChipDisable   = 1'b0;
    localparam int    InstWordBytes = 4;

    typedef struct packed {
        InstAddr_t pc;
        Inst_t     inst;
    } fetch_entry_t;

    function automatic InstAddr_t align_word(input InstAddr_t addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Synchronous FIFO of fetch entries; clear empties it with the same priority as rst.
module inst_fifo
    import inst_prefetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               push,
    input  logic               pop,
    input  fetch_entry_t       din,
    output logic [CW-1:0]      count,
    output fetch_entry_t       head
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst == RstEnable || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/inst_prefetch.sv
// Instruction fetch initiator: owns the PC, drives the ROM port and feeds decode from a prefetch queue.
module inst_prefetch
    import inst_prefetch_pkg::*;
#(
    parameter int        DEPTH    = 4,
    parameter InstAddr_t RESET_PC = 32'h0000_0000
) (
    input  logic      clk,
    input  logic      rst,
    output logic      rom_ce,
    output InstAddr_t rom_addr,
    input  Inst_t     rom_inst,
    input  logic      flush,
    input  InstAddr_t flush_pc,
    output logic      id_valid,
    input  logic      id_ready,
    output InstAddr_t id_pc,
    output Inst_t     id_inst
);

    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    InstAddr_t     pc;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    fetch_entry_t  din;
    fetch_entry_t  head;

    assign id_valid = (count != '0) && !flush;
    assign pop      = id_valid && id_ready && !flush;
    // A full queue may still accept a fetch when the head leaves in the same cycle.
    assign push     = (rom_ce == ChipEnable) && !flush && ((count < FULL) || pop);

    assign din.pc   = pc;
    assign din.inst = rom_inst;

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pc     <= RESET_PC;
            rom_ce <= ChipDisable;
        end else begin
            rom_ce <= ChipEnable;
            if (flush) begin
                pc <= align_word(flush_pc);
            end else if (push) begin
                pc <= pc + 32'(InstWordBytes);
            end
        end
    end

    inst_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .count (count),
        .head  (head)
    );

    assign rom_addr = pc;
    assign id_pc    = head.pc;
    assign id_inst  = head.inst;

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed and randomized checks of inst_prefetch against a queue-based fetch model.
module tb_inst_prefetch;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_inst;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    logic        rom_ce2;
    logic [31:0] rom_addr2;
    logic [31:0] rom_inst2;
    logic        flush2 = 1'b0;
    logic [31:0] flush_pc2 = 32'h0;
    logic        id_valid2;
    logic        id_ready2 = 1'b1;
    logic [31:0] id_pc2;
    logic [31:0] id_inst2;

    int checks = 0;
    int errors = 0;

    ent_t        q[$];
    logic [31:0] m_pc;
    logic        m_ce;
    bit          m_known = 0;

    bit   rec2 = 0;
    ent_t got2[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return a >> 2;
    endfunction

    assign rom_inst  = rom_word(rom_addr);
    assign rom_inst2 = rom_word(rom_addr2);

    inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .flush(flush), .flush_pc(flush_pc), .id_valid(id_valid), .id_ready(id_ready),
        .id_pc(id_pc), .id_inst(id_inst)
    );

    inst_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst(rst), .rom_ce(rom_ce2), .rom_addr(rom_addr2), .rom_inst(rom_inst2),
        .flush(flush2), .flush_pc(flush_pc2), .id_valid(id_valid2), .id_ready(id_ready2),
        .id_pc(id_pc2), .id_inst(id_inst2)
    );

    always @(negedge clk) begin
        if (rec2 && id_valid2) begin
            ent_t e;
            e.pc   = id_pc2;
            e.inst = id_inst2;
            got2.push_back(e);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: compare outputs against the model mid-cycle, then advance the model.
    task automatic cyc();
        bit   exp_valid;
        bit   do_pop;
        bit   do_push;
        ent_t e;
        @(negedge clk);
        if (m_known) begin
            exp_valid = (q.size() != 0) && !flush;
            check("id_valid", {31'b0, id_valid}, {31'b0, exp_valid});
            check("rom_ce", {31'b0, rom_ce}, {31'b0, m_ce});
            check("rom_addr", rom_addr, m_pc);
            if (q.size() != 0) begin
                check("id_pc", id_pc, q[0].pc);
                check("id_inst", id_inst, q[0].inst);
            end else begin
                check("id_pc_empty", id_pc, 32'h0);
                check("id_inst_empty", id_inst, 32'h0);
            end
            do_pop  = exp_valid && id_ready;
            do_push = m_ce && !flush && ((q.size() < DEPTH) || do_pop);
        end else begin
            do_pop  = 0;
            do_push = 0;
        end
        if (rst) begin
            q.delete();
            m_pc    = 32'h0;
            m_ce    = 0;
            m_known = 1;
        end else if (m_known) begin
            if (flush) begin
                q.delete();
                m_pc = {flush_pc[31:2], 2'b00};
            end else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) begin
                    e.pc   = m_pc;
                    e.inst = rom_word(m_pc);
                    q.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
            m_ce = 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, then decode always ready: one entry per cycle after a one-cycle fetch latency.
        rst = 1; flush = 0; id_ready = 0;
        cyc();
        check("t1_ce_in_reset", {31'b0, rom_ce}, 32'h0);
        check("t1_valid_in_reset", {31'b0, id_valid}, 32'h0);
        rst = 0; id_ready = 1; rec2 = 1;
        cyc();
        check("t1_ce_rise", {31'b0, rom_ce}, 32'h1);
        check("t1_valid_first", {31'b0, id_valid}, 32'h0);
        check("t1_addr_first", rom_addr, 32'h0);
        cyc();
        check("t1_valid_next", {31'b0, id_valid}, 32'h1);
        check("t1_pc0", id_pc, 32'h0);
        check("t1_inst0", id_inst, 32'h0);
        cyc();
        check("t1_pc1", id_pc, 32'h4);
        check("t1_inst1", id_inst, 32'h1);
        repeat (4) cyc();
        rec2 = 0;

        // Wrapping reset PC seen on the second instance.
        checks++;
        assert (got2.size() >= 4)
        else begin
            errors++;
            $error("FAIL t5_count: observed %0d expected >=4", got2.size());
        end
        if (got2.size() >= 4) begin
            check("t5_pc0", got2[0].pc, 32'hFFFF_FFF8);
            check("t5_pc1", got2[1].pc, 32'hFFFF_FFFC);
            check("t5_pc2", got2[2].pc, 32'h0000_0000);
            check("t5_pc3", got2[3].pc, 32'h0000_0004);
            check("t5_inst2", got2[2].inst, 32'h0);
            check("t5_inst0", got2[0].inst, 32'h3FFF_FFFE);
        end

        // Decode stalled: queue saturates and the PC holds.
        rst = 1; id_ready = 0;
        cyc();
        rst = 0;
        repeat (8) cyc();
        check("t2_addr_hold", rom_addr, 32'd16);
        check("t2_head", id_pc, 32'h0);
        check("t2_valid", {31'b0, id_valid}, 32'h1);

        // Single-cycle accept while full: pop and push on the same edge.
        id_ready = 1;
        cyc();
        id_ready = 0;
        check("t3_head", id_pc, 32'h4);
        check("t3_addr", rom_addr, 32'd20);
        cyc();
        check("t3_still_full", rom_addr, 32'd20);
        id_ready = 1;
        repeat (3) cyc();

        // Mid-stream redirect with misaligned target.
        flush = 1; flush_pc = 32'h0000_0103;
        cyc();
        flush = 0;
        check("t4_valid_after", {31'b0, id_valid}, 32'h0);
        check("t4_addr", rom_addr, 32'h0000_0100);
        cyc();
        check("t4_valid", {31'b0, id_valid}, 32'h1);
        check("t4_pc0", id_pc, 32'h0000_0100);
        cyc();
        check("t4_pc1", id_pc, 32'h0000_0104);
        repeat (3) cyc();

        // Back-to-back flushes: the last target wins.
        flush = 1; flush_pc = 32'h0000_0400;
        cyc();
        flush_pc = 32'h0000_0802;
        cyc();
        flush = 0;
        cyc();
        check("t4b_pc", id_pc, 32'h0000_0800);

        // Reset and flush together with three entries queued.
        rst = 1; id_ready = 0;
        cyc();
        rst = 0;
        repeat (4) cyc();
        rst = 1; flush = 1; flush_pc = 32'h0000_0200;
        cyc();
        rst = 0; flush = 0;
        #1;
        check("t6_valid", {31'b0, id_valid}, 32'h0);
        check("t6_ce", {31'b0, rom_ce}, 32'h0);
        check("t6_pc", rom_addr, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst      = ($urandom_range(0, 59) == 0);
            flush    = ($urandom_range(0, 11) == 0);
            id_ready = ($urandom_range(0, 9) < 6);
            if ($urandom_range(0, 3) == 0)
                flush_pc = 32'hFFFF_FFE0 | ($urandom & 32'h1F);
            else
                flush_pc = $urandom;
            cyc();
        end
        rst = 0; flush = 0; id_ready = 1;
        repeat (4) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_prefetch.md
Name: inst_prefetch

Overview:
- Instruction-fetch initiator for the instruction ROM port.
- Owns the PC and drives the ROM chip-enable and address.
- Captures the combinational ROM response into a small prefetch queue.
- Presents {pc, inst} pairs to the decode stage over a valid/ready handshake; branch/exception redirects flush the queue and reload the PC.

Parameters:
- DEPTH, 4: queue entries. Power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset. Word-aligned.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  synchronous reset, active-high (`RstEnable = 1'b1)
- rom_ce  out  1  ROM chip enable (`ChipEnable / `ChipDisable)
- rom_addr  out  InstAddr_t (32)  byte address to ROM; always equal to current PC
- rom_inst  in  Inst_t (32)  ROM data, valid combinationally in the same cycle as rom_addr
- flush  in  1  redirect request from branch/exception logic
- flush_pc  in  InstAddr_t  redirect target; bits [1:0] ignored (treated as 0)
- id_valid  out  1  head entry available to decode
- id_ready  in  1  decode accepts head entry this cycle
- id_pc  out  InstAddr_t  PC of head entry
- id_inst  out  Inst_t  instruction of head entry

Behaviour:
- Reset (rst=1 at a clock edge):
  - pc <= RESET_PC, rom_ce <= `ChipDisable, count <= 0, rd/wr pointers <= 0.
  - id_valid=0; id_pc=0 and id_inst=`ZeroWord while empty.
  - Reset mid-operation discards all queued entries with no further output.
- rom_ce is a register: 0 during reset, 1 from the first edge with rst=0. The first fetch happens one cycle after reset deasserts.
- Pop: pop = id_valid & id_ready & ~flush.
- Push: push = rom_ce & ~flush & (count<DEPTH | pop). Push writes {pc, rom_inst} at wr_ptr and sets pc <= pc+4.
  - pc wraps 32'hFFFF_FFFC -> 32'h0 (mod-2^32 add).
  - No push means pc holds.
- Full + pop in the same cycle: the push is permitted; count stays DEPTH.
- Empty + push: the entry becomes visible the next cycle. There is no bypass, so fetch-to-decode latency is 1 cycle.
- id_valid = (count!=0) & ~flush. id_pc and id_inst come combinationally from the entry at rd_ptr.
- Pop advances rd_ptr. Push advances wr_ptr. Both pointers wrap modulo DEPTH.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. Width is $clog2(DEPTH+1).
- Flush (priority over everything except rst):
  - count <= 0, rd_ptr <= wr_ptr <= 0, pc <= {flush_pc[31:2], 2'b00}.
  - Fetch from the new pc starts the next cycle; the first redirected entry reaches decode 2 cycles after flush.
  - id_valid=0 in the flush cycle. Neither push nor pop occurs in it.
  - Back-to-back flush cycles: the last flush_pc wins.
- id_ready=0 with a non-empty queue: the head entry and its outputs stay stable until accepted. The queue fills to DEPTH, then pc holds.
- id_ready is allowed to be high while the queue is empty; no effect.

Decomposition:
- The shared package / defines.svh already provides InstAddr_t, Inst_t, `ZeroWord, `RstEnable, `ChipEnable, `ChipDisable.
- Add to the shared package:
  - typedef struct packed {InstAddr_t pc; Inst_t inst;} fetch_entry_t
  - `InstWordBytes = 4
- One sub-module: inst_fifo.
  - Parameterised sync FIFO of fetch_entry_t with push, pop, clear, count, head.
  - clear has the same priority as rst.
- inst_prefetch holds the PC, rom_ce register and push/pop/flush control.

Test Plan:
1. Reset, then id_ready=1 constantly, ROM word[i]=i:
   - rom_ce rises 1 cycle after rst falls.
   - id_valid from the following cycle, with id_pc=0,4,8,… and id_inst=0,1,2,… one per cycle, no bubbles.
2. id_ready=0 after reset:
   - count saturates at 4 with entries pc 0,4,8,12; rom_addr holds at 16.
   - Raising id_ready drains 0,4,8,12 then continues with 16 without a gap.
3. Full queue, id_ready=1 for a single cycle:
   - pc 0 pops and pc 16 is pushed in the same edge; count remains 4.
4. Mid-stream flush with flush_pc=32'h0000_0103:
   - id_valid=0 that cycle and the next.
   - Then id_pc=32'h0000_0100, 0x104, …; no stale entry (pc 8/12) ever appears after the flush.
5. RESET_PC=32'hFFFF_FFF8, id_ready=1:
   - Entries FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
6. rst asserted while the queue holds 3 entries and flush=1 simultaneously:
   - Next cycle id_valid=0, rom_ce=0, pc=RESET_PC; the flush target is ignored.
